mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-outstanding memory port
//
// Purpose:
//   Arbitrates a fetch port and a data port onto a single memory port with
//   exactly one transaction outstanding. The winner's fields are latched in
//   IDLE and held on m_* until the memory grants.
//
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//   between requesters (the one that was not granted last wins). When
//   undefined, data always beats fetch.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   i_req/i_addr                  fetch request in
//   i_gnt/i_rvalid/i_rdata        fetch grant, response pulse, read data
//   d_req/d_we/d_be/d_addr/d_wdata data request in
//   d_gnt/d_rvalid/d_rdata        data grant, response pulse, read data
//   m_req/m_we/m_be/m_addr/m_wdata memory request out
//   m_gnt/m_rvalid/m_rdata        memory grant, response, read data in
//   busy                          high whenever a transaction is in flight

module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;

  // owner_q: 1 = data port owns the transaction, 0 = fetch port
  logic        owner_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        pick_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_owner_q uses the same encoding as owner_q; reset value is fetch so
  // the first contested arbitration goes to data.
  logic        last_owner_q;

  always_comb begin
    pick_data = d_req;
    if (i_req && d_req) begin
      pick_data = ~last_owner_q;
    end
  end
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && (i_req || d_req)) begin
        owner_q <= pick_data;
        we_q    <= pick_data ? d_we    : 1'b0;
        be_q    <= pick_data ? d_be    : 4'hF;
        addr_q  <= pick_data ? d_addr  : i_addr;
        wdata_q <= pick_data ? d_wdata : 32'h0;
      end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (state == REQ && m_gnt) begin
        last_owner_q <= owner_q;
      end
`endif
    end
  end

  // Read data is a pure pass-through; only the owner's rvalid qualifies it.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_be      = 4'h0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        // m_rvalid is deliberately not looked at here.
        if (i_req || d_req) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        m_req   = 1'b1;
        m_we    = we_q;
        m_be    = be_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (m_gnt) begin
          i_gnt = ~owner_q;
          d_gnt = owner_q;
          // A response coinciding with the grant completes immediately.
          if (m_rvalid) begin
            i_rvalid  = ~owner_q;
            d_rvalid  = owner_q;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (m_rvalid) begin
          i_rvalid  = ~owner_q;
          d_rvalid  = owner_q;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
